// File: rtl/div_sequencer.sv
// Multi-cycle RV64M divide/remainder unit (DIV/DIVU/REM/REMU and -W forms).
// Radix-2 restoring shift-subtract; divide-by-zero and signed overflow resolve early.
module div_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [2:0]  funct3,
    input  logic        width_32,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]  fn_q;
    logic        w32_q;
    logic [63:0] a_q;
    logic [63:0] b_q;
    // Dividend bits leave from the top while quotient bits enter at the bottom.
    logic [63:0] dvd_q;
    logic [63:0] dvs_q;
    logic [63:0] rem_q;
    logic [6:0]  cnt_q;
    logic        neg_q;
    logic        neg_r;
    logic [63:0] result_q;

    // Operand extraction and special-case detection, consumed in PREP.
    logic        is_signed;
    logic        sa;
    logic        sb;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] a_sx;
    logic [63:0] a_mag;
    logic [63:0] b_mag;
    logic        b_zero;
    logic        ovf;
    logic        special;
    logic [63:0] special_res;

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        is_signed   = ~fn_q[0];
        a_ext       = a_q;
        b_ext       = b_q;
        a_sx        = a_q;
        if (w32_q) begin
            a_sx  = {{32{a_q[31]}}, a_q[31:0]};
            a_ext = is_signed ? {{32{a_q[31]}}, a_q[31:0]} : {32'b0, a_q[31:0]};
            b_ext = is_signed ? {{32{b_q[31]}}, b_q[31:0]} : {32'b0, b_q[31:0]};
        end
        sa          = is_signed & a_ext[63];
        sb          = is_signed & b_ext[63];
        a_mag       = sa ? (64'd0 - a_ext) : a_ext;
        b_mag       = sb ? (64'd0 - b_ext) : b_ext;
        b_zero      = (b_ext == 64'd0);
        ovf         = is_signed && (b_ext == {64{1'b1}}) &&
                      (a_ext == (w32_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special     = ~fn_q[2] | b_zero | ovf;
        special_res = 64'd0;
        if (!fn_q[2]) begin
            special_res = 64'h0000_0000_DEAD_BEEF;
        end else if (b_zero) begin
            special_res = fn_q[1] ? a_sx : {64{1'b1}};
        end else begin
            special_res = fn_q[1] ? 64'd0 : a_ext;
        end
    end

    // One restoring step; the shifted remainder needs N+1 bits before the compare.
    logic [64:0] rem_sh;
    logic [63:0] rem_sub;
    logic        take;

    always_comb begin
        rem_sh  = {rem_q, dvd_q[63]};
        take    = (rem_sh >= {1'b0, dvs_q});
        rem_sub = rem_sh[63:0] - dvs_q;
    end

    // Sign fix-up and selection; -W results are always sign-extended from bit 31.
    logic [63:0] q_raw;
    logic [63:0] q_fix;
    logic [63:0] r_fix;
    logic [63:0] sel;
    logic [63:0] fix_res;

    always_comb begin
        q_raw   = w32_q ? {32'b0, dvd_q[31:0]} : dvd_q;
        q_fix   = neg_q ? (64'd0 - q_raw) : q_raw;
        r_fix   = neg_r ? (64'd0 - rem_q) : rem_q;
        sel     = fn_q[1] ? r_fix : q_fix;
        fix_res = w32_q ? {{32{sel[31]}}, sel[31:0]} : sel;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid && !flush) state_nxt = PREP;
            PREP: state_nxt = special ? DONE : ITER;
            ITER: if (cnt_q == 7'd1) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fn_q     <= 3'd0;
            w32_q    <= 1'b0;
            a_q      <= 64'd0;
            b_q      <= 64'd0;
            dvd_q    <= 64'd0;
            dvs_q    <= 64'd0;
            rem_q    <= 64'd0;
            cnt_q    <= 7'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        fn_q  <= funct3;
                        w32_q <= width_32;
                        a_q   <= a;
                        b_q   <= b;
                    end
                end
                PREP: begin
                    dvd_q <= w32_q ? {a_mag[31:0], 32'b0} : a_mag;
                    dvs_q <= b_mag;
                    rem_q <= 64'd0;
                    cnt_q <= w32_q ? 7'd32 : 7'd64;
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    if (special) result_q <= special_res;
                end
                ITER: begin
                    rem_q <= take ? rem_sub : rem_sh[63:0];
                    dvd_q <= {dvd_q[62:0], take};
                    cnt_q <= cnt_q - 7'd1;
                end
                FIX: begin
                    result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset && state == PREP) begin
            assert (fn_q[2]) else $error("div_sequencer: illegal funct3 %b", fn_q);
        end
    end

    assign in_ready  = (state == IDLE) && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer: results, latencies,
// output back-pressure, flush and asynchronous reset.
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  funct3;
    logic        width_32;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    int checks   = 0;
    int failures = 0;

    div_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .funct3    (funct3),
        .width_32  (width_32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure latency to out_valid,
    // optionally hold off the consumer, then complete the handshake.
    task automatic run_op(input string tag, input logic [2:0] fn, input logic w,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] exp, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        funct3   = fn;
        width_32 = w;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = 64'h0123_4567_89AB_CDEF;
        funct3   = 3'b001;
        width_32 = ~w;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 200);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_hold_res"}, result, exp);
            check({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_after_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_after_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 64'd0;
        b         = 64'd0;
        funct3    = 3'd0;
        width_32  = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Main function, 64-bit.
        run_op("divu_100_7", F_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 67, 5);
        run_op("remu_100_7", F_REMU, 1'b0, 64'd100, 64'd7, 64'd2, 67, 0);
        run_op("div_m100_7", F_DIV, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 67, 0);
        run_op("rem_m100_7", F_REM, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 67, 0);
        run_op("rem_100_m7", F_REM, 1'b0, 64'd100, -64'sd7, 64'd2, 67, 0);
        run_op("div_100_m7", F_DIV, 1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 67, 0);
        run_op("rem_m100_m7", F_REM, 1'b0, -64'sd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFE, 67, 0);
        run_op("divu_max_3", F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
               64'h5555_5555_5555_5555, 67, 0);
        run_op("remu_max_big", F_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
               64'h7FFF_FFFF_FFFF_FFFE, 67, 0);

        // Divide by zero and signed overflow take the early path.
        run_op("divu_by0", F_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("remu_by0", F_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 2, 0);
        run_op("divw_by0", F_DIV, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("div_ovf", F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 2, 0);
        run_op("rem_ovf", F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd0, 2, 0);
        run_op("divw_ovf", F_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 2, 0);

        // -W truncation and sign-extension.
        run_op("divuw_trunc", F_DIVU, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'd1,
               64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
        run_op("remw_trunc", F_REM, 1'b1, 64'd7, 64'hDEAD_0000_0000_0002, 64'd1, 35, 0);
        run_op("divw_neg", F_DIV, 1'b1, 64'hABCD_0000_FFFF_FF9C, 64'd7,
               64'hFFFF_FFFF_FFFF_FFF2, 35, 0);
        run_op("remuw_f", F_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'hF, 35, 0);

        // Flush in cycle k+10 kills the op.
        @(negedge clk);
        funct3   = F_DIVU;
        width_32 = 1'b0;
        a        = 64'd1000;
        b        = 64'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) @(negedge clk);
        check("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_busy", {63'd0, busy}, 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'd0);

        // flush together with in_valid: the op is not taken.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_blocks_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        check("flush_blocks_accept", {63'd0, busy}, 64'd0);

        // Asynchronous reset mid-ITER.
        @(negedge clk);
        funct3   = F_DIVU;
        width_32 = 1'b0;
        a        = 64'd999;
        b        = 64'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("midop_busy", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);

        run_op("post_rst_div", F_DIV, 1'b0, 64'd999, -64'sd10, 64'hFFFF_FFFF_FFFF_FF9D, 67, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
